alu_control_seq: RTL
====================

// Module: alu_control_seq
// PURPOSE
//  Parametrised, registered ALU control unit for the MIPS datapath. Decodes {ALUOp,funct} into
//  an ALU operation code and sequences multi-cycle MULT/DIV with a busy/stall handshake.
//  Sits between the main control unit and the ALU/HI-LO unit in the execute stage.
// PARAMETERS
//  OPER_W      4  width of alu_operation_o (>=4; codes below zero-extended)
//  CNT_W       4  width of the cycle counter
//  MUL_CYCLES  4  execute cycles for MULT (1 .. 2**CNT_W-1)
//  DIV_CYCLES  8  execute cycles for DIV  (1 .. 2**CNT_W-1)
// PORTS
//  clk              in   1       clock, rising edge
//  reset            in   1       asynchronous, active-low reset
//  issue_i          in   1       decode stage presents a valid instruction
//  alu_op_i         in   3       ALUOp from main control
//  funct_i          in   6       instruction funct field
//  flush_i          in   1       abort in-flight multi-cycle op
//  alu_operation_o  out  OPER_W  registered ALU operation code
//  op_valid_o       out  1       1-cycle pulse: new alu_operation_o accepted
//  busy_o           out  1       multi-cycle op executing
//  stall_o          out  1       combinational: issue_i & busy_o
//  done_o           out  1       1-cycle pulse: multi-cycle op finished
//  hilo_we_o        out  1       HI/LO write enable, equal to done_o
// BEHAVIOUR
//  - Reset (reset=0, any time, async): state IDLE, counter 0, every output 0.
//  - Decode ({alu_op_i,funct_i}, x = don't care):
//    000_100100 AND->0000; 000_100101 OR->0001; 000_100000 ADD->0011; 000_100010 SUB->0100
//    000_100111 NOR->1001; 000_000000 SLL->1100; 000_000010 SRL->0110; 000_101010 SLT->0101
//    000_011000 MULT->0111 (multi); 000_011010 DIV->1000 (multi)
//    001_xxxxxx ADDI->0011; 010_xxxxxx ORI->0001; 011_xxxxxx LUI->1010
//    100_xxxxxx LW->1110; 101_xxxxxx SW->1111; anything else -> default (see CONFIGURATION)
//  - Accept: issue_i=1 and state IDLE or DONE and flush_i=0. Edge N accept ->
//    alu_operation_o valid and op_valid_o=1 during cycle N+1; output holds until next accept.
//  - FSM IDLE/RUN/DONE:
//    IDLE: accept single-cycle op -> stay IDLE; accept MULT/DIV -> RUN, cnt=CYCLES-1.
//    RUN : busy_o=1; cnt!=0 -> cnt-1; cnt==0 -> DONE. issue_i ignored, stall_o=issue_i.
//    DONE: done_o=hilo_we_o=1, busy_o=0; accepts issue same as IDLE; else -> IDLE.
//  - busy_o high exactly CYCLES cycles (N+1..N+CYCLES); done_o at N+CYCLES+1.
//  - flush_i=1 in RUN: next state IDLE, cnt=0, no done_o; alu_operation_o holds.
//  - flush_i=1 with issue_i=1 in IDLE/DONE: issue dropped, no op_valid_o.
//  - flush_i in DONE: result already committed, done_o still asserted that cycle.
//  - Back-to-back: MULT accepted in DONE starts a new RUN with no idle cycle.
// CONFIGURATION
//  ALU_CTRL_ILLEGAL_TRAP_EN defined: adds port illegal_o (out,1), registered, pulses with
//    op_valid_o when accepted selector is not in the table; alu_operation_o = 0 (AND), no RUN.
//  Not defined: no illegal_o port; unknown selector -> alu_operation_o=1001 (NOR), no flag.
// TESTING
//  1 reset=0 mid-RUN of DIV -> all outputs 0 immediately (async), state IDLE after release.
//  2 issue ADD (000_100000) at edge N -> N+1: alu_operation_o=0011, op_valid_o=1, busy_o=0.
//  3 issue MULT, MUL_CYCLES=4, issue_i held 1 -> busy_o=1 and stall_o=1 for 4 cycles, then
//    done_o=hilo_we_o=1 for 1 cycle; next op accepted in the DONE cycle.
//  4 issue DIV, flush_i=1 on 3rd busy cycle -> busy_o=0 next cycle, done_o never asserted.
//  5 selector 000_111111 -> with _EN: illegal_o=1, alu_operation_o=0000; without: 1001.
//  6 MUL_CYCLES=1, DIV_CYCLES=15 -> busy 1 and 15 cycles respectively, done_o single pulse.

Source files
------------

// File: rtl/alu_control_seq.sv
// Registered MIPS ALU control: decodes {ALUOp,funct} and sequences multi-cycle MULT/DIV.
// Define ALU_CTRL_ILLEGAL_TRAP_EN to add illegal_o and map unknown selectors to AND.
module alu_control_seq #(
    parameter int OPER_W     = 4,
    parameter int CNT_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_i,
    input  logic [2:0]        alu_op_i,
    input  logic [5:0]        funct_i,
    input  logic              flush_i,
    output logic [OPER_W-1:0] alu_operation_o,
    output logic              op_valid_o,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              hilo_we_o
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic              illegal_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // The counter is loaded with CYCLES-1 so RUN lasts exactly CYCLES cycles.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPER_W-1:0]  alu_operation_q, alu_operation_d;
    logic               op_valid_q, op_valid_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic               illegal_q, illegal_d;
`endif

    logic [3:0] dec_code;
    logic       dec_multi;
    logic       dec_is_div;
    logic       dec_illegal;

    always_comb begin
        dec_code    = 4'b0000;
        dec_multi   = 1'b0;
        dec_is_div  = 1'b0;
        dec_illegal = 1'b0;
        case (alu_op_i)
            3'b000: begin
                case (funct_i)
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b100000: dec_code = 4'b0011;
                    6'b100010: dec_code = 4'b0100;
                    6'b100111: dec_code = 4'b1001;
                    6'b000000: dec_code = 4'b1100;
                    6'b000010: dec_code = 4'b0110;
                    6'b101010: dec_code = 4'b0101;
                    6'b011000: begin
                        dec_code  = 4'b0111;
                        dec_multi = 1'b1;
                    end
                    6'b011010: begin
                        dec_code   = 4'b1000;
                        dec_multi  = 1'b1;
                        dec_is_div = 1'b1;
                    end
                    default:   dec_illegal = 1'b1;
                endcase
            end
            3'b001:  dec_code = 4'b0011;
            3'b010:  dec_code = 4'b0001;
            3'b011:  dec_code = 4'b1010;
            3'b100:  dec_code = 4'b1110;
            3'b101:  dec_code = 4'b1111;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            dec_code = 4'b0000;
`else
            dec_code = 4'b1001;
`endif
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        alu_operation_d = alu_operation_q;
        op_valid_d      = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegal_d       = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // IDLE and DONE accept identically; DONE always falls back to IDLE.
            default: begin
                state_d = IDLE;
                if (issue_i && !flush_i) begin
                    alu_operation_d = OPER_W'(dec_code);
                    op_valid_d      = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    illegal_d       = dec_illegal;
`endif
                    if (dec_multi) begin
                        state_d = RUN;
                        cnt_d   = dec_is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            alu_operation_q <= '0;
            op_valid_q      <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            alu_operation_q <= alu_operation_d;
            op_valid_q      <= op_valid_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            illegal_q       <= illegal_d;
`endif
        end
    end

    assign alu_operation_o = alu_operation_q;
    assign op_valid_o      = op_valid_q;
    assign busy_o          = (state_q == RUN);
    assign done_o          = (state_q == DONE);
    assign hilo_we_o       = done_o;
    assign stall_o         = issue_i & busy_o;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    assign illegal_o       = illegal_q;
`endif

endmodule
